// File: rtl/spart_pkg.sv
// Shared types and defaults for the SPART receive controller.
package spart_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_BIT_PULSES = 10;
  localparam int unsigned DIV_W          = 16;
  localparam int unsigned DATA_W         = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    SAMPLING = 1'b1
  } baud_state_e;

  // A bit period shorter than two clocks cannot place a mid-bit sample.
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] div);
    return (div < DIV_W'(2)) ? DIV_W'(2) : div;
  endfunction

endpackage

// File: rtl/spart_rx_ctrl_if.sv
// Receiver-side and consumer-side signals of the SPART receive controller.
interface spart_rx_ctrl_if
  import spart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0]  divisor;
  logic              receive_start;
  logic              rda;
  logic [DATA_W-1:0] receive_line;
  logic              receive_baud;
  logic              receive_read_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rx_valid;
  logic [CW-1:0]     rx_count;
  logic              overrun;
  logic              clr_overrun;

  modport slave (
    input  divisor, receive_start, rda, receive_line, rd_en, clr_overrun,
    output receive_baud, receive_read_en, rd_data, rx_valid, rx_count, overrun
  );

  modport master (
    output divisor, receive_start, rda, receive_line, rd_en, clr_overrun,
    input  receive_baud, receive_read_en, rd_data, rx_valid, rx_count, overrun
  );

endinterface

// File: rtl/spart_rx_fifo.sv
// Show-ahead receive byte FIFO; pointers carry an extra wrap bit to tell full from empty.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head,
  output logic                          valid,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0]     wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              valid_q, valid_d;
  logic              empty_c, pop_c, push_c;

  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_c   = pop & ~empty_c;
  assign push_c  = push & (~full_c | pop_c);

  // Head register looks at the post-update storage so it is valid the cycle after any push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_c) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + CW'(1);
    end
    if (pop_c) begin
      rd_d = rd_q + CW'(1);
    end
    count_d = wr_d - rd_d;
    valid_d = (wr_d != rd_d);
    head_d  = mem_d[rd_d[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/spart_rx_ctrl.sv
// SPART receive controller: baud pulse generator for the receiver and a byte drain into a FIFO.
module spart_rx_ctrl
  import spart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned BIT_PULSES = DEF_BIT_PULSES
) (
  input  logic           clk,
  input  logic           rst_n,
  spart_rx_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(BIT_PULSES + 1);

  baud_state_e       state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d, eff_div_c;
  logic [PW-1:0]     pulses_q, pulses_d;
  logic              baud_q, baud_d;
  logic              read_en_q, read_en_d;
  logic              overrun_q, overrun_d;
  logic              drain_c, drop_c, full_c;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_valid;
  logic [CW-1:0]     fifo_count;

  assign eff_div_c = eff_divisor(bus.divisor);

  // The pulse is registered one cycle ahead so receive_baud is high exactly while cnt is zero.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    baud_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.receive_start) begin
          div_d    = eff_div_c;
          cnt_d    = eff_div_c >> 1;
          pulses_d = PW'(BIT_PULSES);
          state_d  = SAMPLING;
        end
      end
      SAMPLING: begin
        baud_d = (cnt_q == DIV_W'(1));
        if (cnt_q == '0) begin
          cnt_d    = div_q - DIV_W'(1);
          pulses_d = pulses_q - PW'(1);
          if (pulses_q == PW'(1)) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still accepts the byte when the consumer pops in the same cycle.
  assign drain_c = bus.rda & ~read_en_q;
  assign drop_c  = drain_c & full_c & ~bus.rd_en;

  always_comb begin
    read_en_d = drain_c;
    overrun_d = drop_c | (overrun_q & ~bus.clr_overrun);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      pulses_q  <= '0;
      baud_q    <= 1'b0;
      read_en_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pulses_q  <= pulses_d;
      baud_q    <= baud_d;
      read_en_q <= read_en_d;
      overrun_q <= overrun_d;
    end
  end

  spart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (drain_c & ~drop_c),
    .push_data (bus.receive_line),
    .pop       (bus.rd_en),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count),
    .full_c    (full_c)
  );

  assign bus.receive_baud    = baud_q;
  assign bus.receive_read_en = read_en_q;
  assign bus.overrun         = overrun_q;
  assign bus.rd_data         = fifo_head;
  assign bus.rx_valid        = fifo_valid;
  assign bus.rx_count        = fifo_count;

endmodule

// File: tb/tb_spart_rx_ctrl.sv
// Scoreboard bench for spart_rx_ctrl: a byte-queue / pulse-schedule model predicts, a negedge monitor compares.
module tb_spart_rx_ctrl;
  import spart_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned BP    = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_rx_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus();

  spart_rx_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .BIT_PULSES(BP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  byte unsigned exp_q[$];     // bytes the consumer should read, in order
  int           exp_baud[$];  // cycles at which receive_baud must be high
  byte unsigned src[$];       // bytes the receiver model still has to deliver
  int mcount     = 0;
  bit m_overrun  = 1'b0;
  bit m_ack      = 1'b0;
  int last_pulse = -1;
  bit gap_en     = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Advance one clock and fold the inputs of the cycle just ended into the model.
  task automatic tick();
    int s, d, t;
    bit pop, drain, push, consumed;
    @(posedge clk);
    #1;
    consumed = 1'b0;
    if (rst_n) begin
      s        = cyc - 1;
      consumed = m_ack;
      pop      = bus.rd_en && (mcount > 0);
      drain    = bus.rda && !m_ack;
      push     = drain && ((mcount < int'(DEPTH)) || bus.rd_en);
      if (push) exp_q.push_back(bus.receive_line);
      m_overrun = (drain && !push) || (m_overrun && !bus.clr_overrun);
      mcount    = mcount - int'(pop) + int'(push);
      m_ack     = drain;
      if (bus.receive_start && s > last_pulse) begin
        d = (bus.divisor < 16'd2) ? 2 : int'(bus.divisor);
        t = s + d / 2 + 1;
        for (int k = 0; k < int'(BP); k++) exp_baud.push_back(t + k * d);
        last_pulse = t + (int'(BP) - 1) * d;
      end
    end
    if (consumed) bus.rda = 1'b0;
    if (!bus.rda && src.size() > 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
      bus.rda          = 1'b1;
      bus.receive_line = src.pop_front();
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_reset_values();
    chk("rst_rd_data",  32'(bus.rd_data), 32'h0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    chk("rst_rx_count", 32'(bus.rx_count), 32'h0);
    chk("rst_overrun",  32'(bus.overrun), 32'h0);
    chk("rst_baud",     32'(bus.receive_baud), 32'h0);
    chk("rst_read_en",  32'(bus.receive_read_en), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_baud.delete();
    src.delete();
    mcount     = 0;
    m_overrun  = 1'b0;
    m_ack      = 1'b0;
    last_pulse = -1;
    bus.rda           = 1'b0;
    bus.receive_start = 1'b0;
    bus.rd_en         = 1'b0;
    bus.clr_overrun   = 1'b0;
    #1;
    check_reset_values();
    run(3);
    rst_n = 1'b1;
  endtask

  task automatic start_frame(input logic [15:0] div);
    bus.divisor       = div;
    bus.receive_start = 1'b1;
    tick();
    bus.receive_start = 1'b0;
  endtask

  // Monitor: per-cycle status against the model, pops and baud pulses against the scoreboards.
  always @(negedge clk) begin
    chk("rx_count", 32'(bus.rx_count), 32'(mcount));
    chk("rx_valid", 32'(bus.rx_valid), 32'(mcount != 0));
    chk("overrun",  32'(bus.overrun), 32'(m_overrun));
    chk("read_en",  32'(bus.receive_read_en), 32'(m_ack));
    if (bus.rd_en && bus.rx_valid) begin
      if (exp_q.size() == 0) chk("pop_on_empty", 32'(bus.rx_valid), 32'h0);
      else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
    if (bus.receive_baud) begin
      if (exp_baud.size() == 0) chk("baud_unexpected", 32'(bus.receive_baud), 32'h0);
      else                      chk("baud_cycle", 32'(cyc), 32'(exp_baud.pop_front()));
    end else if (exp_baud.size() > 0 && exp_baud[0] == cyc) begin
      chk("baud_missing", 32'(bus.receive_baud), 32'h1);
      void'(exp_baud.pop_front());
    end
  end

  initial begin
    bus.divisor       = 16'd16;
    bus.receive_start = 1'b0;
    bus.rda           = 1'b0;
    bus.receive_line  = 8'h00;
    bus.rd_en         = 1'b0;
    bus.clr_overrun   = 1'b0;
    run(3);
    check_reset_values();
    rst_n = 1'b1;
    run(2);

    // Divisor 16; a mid-frame start with a new divisor must be ignored.
    start_frame(16'd16);
    run(49);
    start_frame(16'd5);
    run(120);

    // Divisor below 2 behaves as 2, then an odd divisor.
    start_frame(16'd1);
    run(25);
    start_frame(16'd0);
    run(25);
    start_frame(16'd3);
    run(35);

    // Fill the FIFO, then overrun on a fifth byte, then clear.
    src = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
    run(12);
    chk("fill_count", 32'(bus.rx_count), 32'd4);
    src.push_back(8'hFF);
    run(4);
    chk("overrun_set", 32'(bus.overrun), 32'h1);
    bus.clr_overrun = 1'b1;
    tick();
    bus.clr_overrun = 1'b0;
    run(2);
    bus.rd_en = 1'b1;
    run(6);
    bus.rd_en = 1'b0;
    run(2);

    // Full FIFO with a push and pop in the same cycle.
    src = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
    run(12);
    bus.rda          = 1'b1;
    bus.receive_line = 8'h55;
    bus.rd_en        = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    run(4);
    chk("simul_count", 32'(bus.rx_count), 32'd4);
    chk("simul_overrun", 32'(bus.overrun), 32'h0);
    bus.rd_en = 1'b1;
    run(6);
    bus.rd_en = 1'b0;

    // Randomized traffic on both sides.
    gap_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (src.size() < 2) src.push_back(8'($urandom_range(0, 255)));
      bus.rd_en         = (i < 750) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      bus.clr_overrun   = ($urandom_range(0, 19) == 0);
      bus.receive_start = ($urandom_range(0, 29) == 0);
      bus.divisor       = 16'($urandom_range(0, 12));
      tick();
    end
    gap_en            = 1'b0;
    bus.rd_en         = 1'b0;
    bus.clr_overrun   = 1'b0;
    bus.receive_start = 1'b0;
    src.delete();
    run(200);

    // Reset after the fourth pulse of a frame, with data in the FIFO.
    src = '{8'h11, 8'h22};
    run(6);
    start_frame(16'd16);
    run(62);
    do_reset();
    run(30);
    start_frame(16'd16);
    run(160);
    chk("baud_pending", 32'(exp_baud.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
